key_search_master: RTL and testbench

- Consumer end of the key-generator handshake: pulls candidate keys one at a time from the LFSR key source (available / read / finished).
- Drives a single decrypt core with each key and checks the core's validity verdict.
- Stops on the first valid key (FOUND) or when the source reports exhaustion (EXHAUSTED).
- Sits between the key generator and the decrypt datapath in the brute-force top level.

---
 rtl/key_search_if.sv | 34 +++
 rtl/key_search_master.sv | 131 +++++++++++++
 tb/tb_key_search_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_search_if.sv
// Handshake bundle between the brute-force key search master, the key source
// and the decrypt core. master = search engine side, slave = environment side.
interface key_search_if #(
    parameter int KEY_W = 24,
    parameter int ATT_W = 24
);
    logic             start;
    logic             key_available;
    logic             key_finished;
    logic [KEY_W-1:0] key_in;
    logic             key_read;
    logic             dec_start;
    logic [KEY_W-1:0] dec_key;
    logic             dec_done;
    logic             dec_valid;
    logic             busy;
    logic             found;
    logic             exhausted;
    logic             timeout;
    logic [KEY_W-1:0] found_key;
    logic [ATT_W-1:0] attempts;

    modport master (
        input  start, key_available, key_finished, key_in, dec_done, dec_valid,
        output key_read, dec_start, dec_key, busy, found, exhausted, timeout,
               found_key, attempts
    );

    modport slave (
        output start, key_available, key_finished, key_in, dec_done, dec_valid,
        input  key_read, dec_start, dec_key, busy, found, exhausted, timeout,
               found_key, attempts
    );
endinterface

// File: rtl/key_search_master.sv
// Pulls candidate keys from the key source, runs each through one decrypt core,
// stops on the first valid key or on source exhaustion. KEY_SEARCH_TIMEOUT_EN adds a decrypt watchdog.
module key_search_master #(
    parameter int KEY_W          = 24,
    parameter int ATT_W          = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    key_search_if.master ks
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT_DEC,
        S_FOUND,
        S_EXHAUSTED
`ifdef KEY_SEARCH_TIMEOUT_EN
        , S_TIMEOUT
`endif
    } state_t;

    state_t           state;
    logic             dec_start_q;
    logic             busy_q;
    logic             found_q;
    logic             exhausted_q;
    logic [KEY_W-1:0] dec_key_q;
    logic [KEY_W-1:0] found_key_q;
    logic [ATT_W-1:0] attempts_q;

`ifdef KEY_SEARCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Checked one cycle early so the transition lands as the count reaches the limit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            dec_start_q <= 1'b0;
            busy_q      <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            dec_key_q   <= '0;
            found_key_q <= '0;
            attempts_q  <= '0;
`ifdef KEY_SEARCH_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            dec_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ks.start) begin
                        state  <= S_FETCH;
                        busy_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // Exhaustion outranks a key that happens to be presented alongside it.
                    if (ks.key_finished) begin
                        state       <= S_EXHAUSTED;
                        busy_q      <= 1'b0;
                        exhausted_q <= 1'b1;
                    end else if (ks.key_available) begin
                        state       <= S_LAUNCH;
                        dec_key_q   <= ks.key_in;
                        dec_start_q <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_DEC;
`ifdef KEY_SEARCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT_DEC: begin
                    if (ks.dec_done) begin
                        if (attempts_q != '1)
                            attempts_q <= attempts_q + 1'b1;
                        if (ks.dec_valid) begin
                            state       <= S_FOUND;
                            busy_q      <= 1'b0;
                            found_q     <= 1'b1;
                            found_key_q <= dec_key_q;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
`ifdef KEY_SEARCH_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        state     <= S_TIMEOUT;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        wait_cnt  <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // The only combinational output: the source must see the read in the cycle the key is taken.
    assign ks.key_read  = (state == S_FETCH) & ks.key_available & ~ks.key_finished;
    assign ks.dec_start = dec_start_q;
    assign ks.dec_key   = dec_key_q;
    assign ks.busy      = busy_q;
    assign ks.found     = found_q;
    assign ks.exhausted = exhausted_q;
    assign ks.found_key = found_key_q;
    assign ks.attempts  = attempts_q;

`ifdef KEY_SEARCH_TIMEOUT_EN
    assign ks.timeout = timeout_q;
`else
    // Watchdog compiled out; the parameter stays referenced so both builds share one port list.
    localparam bit TIMEOUT_LIVE = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign ks.timeout = TIMEOUT_LIVE;
`endif

endmodule

// File: tb/tb_key_search_master.sv
// Directed bench for key_search_master: behavioural key source and decrypt core,
// scenarios with hand-derived expected results.
module tb_key_search_master;
    localparam int KW = 4;
    localparam int AW = 8;
    localparam int TC = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_search_if #(.KEY_W(KW), .ATT_W(AW)) ksif ();

    key_search_master #(.KEY_W(KW), .ATT_W(AW), .TIMEOUT_CYCLES(TC)) dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ksif)
    );

    int n_vec = 0;
    int n_err = 0;

    // scenario configuration (written by the stimulus block only)
    logic [KW-1:0] keys[$];
    bit            verd[$];
    int            lat = 2;
    bit            nogap = 1'b0;
    bit            fin_en = 1'b0;
    bit            fin_force = 1'b0;
    bit            core_en = 1'b1;
    logic          inj_done = 1'b0;

    // model state
    int   idx = 0, cyc = 0, done_at = -1, v_idx = 0;
    bit   gap = 1'b0;
    logic core_done = 1'b0;

    // observed traffic
    int            n_rd = 0, n_ds = 0, dup = 0, bad_rd = 0, lat_err = 0;
    bit            rd_now = 1'b0, ds_now = 1'b0, rd_out = 1'b0, prev_rd = 1'b0;
    logic [KW-1:0] launched[$];

    assign ksif.dec_done = core_done | inj_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // traffic monitor, mid-cycle
    always @(negedge clk) begin
        rd_now = ksif.key_read;
        ds_now = ksif.dec_start;
        if (reset) begin
            n_rd = 0; n_ds = 0; dup = 0; bad_rd = 0; lat_err = 0;
            rd_out = 1'b0; prev_rd = 1'b0;
            launched.delete();
        end else begin
            if (rd_now) begin
                n_rd++;
                if (rd_out) dup++;
                if (ksif.key_finished) bad_rd++;
                rd_out = 1'b1;
            end
            if (ds_now) begin
                n_ds++;
                launched.push_back(ksif.dec_key);
                if (!prev_rd) lat_err++;
                rd_out = 1'b0;
            end
            prev_rd = rd_now;
        end
    end

    // key source and decrypt core, updated just after each edge
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            idx = 0; gap = 1'b0; cyc = 0; done_at = -1; v_idx = 0;
        end else begin
            cyc++;
            if (rd_now) begin
                idx++;
                gap = !nogap;
            end else begin
                gap = 1'b0;
            end
            if (ds_now && core_en) done_at = cyc + lat;
        end
        core_done = !reset && (cyc == done_at);
        ksif.dec_valid = core_done ? ((v_idx < verd.size()) ? verd[v_idx] : 1'b0) : 1'b1;
        if (core_done) v_idx++;
        ksif.key_available = (idx < keys.size()) && !gap;
        ksif.key_in        = (idx < keys.size()) ? keys[idx] : '0;
        ksif.key_finished  = fin_force || (fin_en && (idx >= keys.size()));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ksif.start = 1'b0;
        inj_done = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic go();
        ksif.start = 1'b1;
        step();
        ksif.start = 1'b0;
    endtask

    task automatic wait_term(input string tag, input int max);
        int k = 0;
        while (!(ksif.found || ksif.exhausted || ksif.timeout) && k < max) begin
            step();
            k++;
        end
        chk(tag, 32'(k < max), 32'd1);
    endtask

    initial begin
        ksif.start = 1'b0;

        // 1: three keys, third one valid
        keys = '{4'hF, 4'h7, 4'h3};
        verd = '{1'b0, 1'b0, 1'b1};
        lat = 2; nogap = 0; fin_en = 0; fin_force = 0; core_en = 1;
        do_reset();
        chk("rst_busy", 32'(ksif.busy), 0);
        chk("rst_found", 32'(ksif.found), 0);
        chk("rst_exh", 32'(ksif.exhausted), 0);
        chk("rst_to", 32'(ksif.timeout), 0);
        chk("rst_att", 32'(ksif.attempts), 0);
        chk("rst_dkey", 32'(ksif.dec_key), 0);
        chk("rst_fkey", 32'(ksif.found_key), 0);
        chk("rst_krd", 32'(ksif.key_read), 0);
        go();
        chk("t1_busy_run", 32'(ksif.busy), 1);
        wait_term("t1_done", 200);
        chk("t1_found", 32'(ksif.found), 1);
        chk("t1_fkey", 32'(ksif.found_key), 32'h3);
        chk("t1_att", 32'(ksif.attempts), 3);
        chk("t1_busy", 32'(ksif.busy), 0);
        chk("t1_nrd", 32'(n_rd), 3);
        chk("t1_k0", 32'(launched[0]), 32'hF);
        chk("t1_k1", 32'(launched[1]), 32'h7);
        chk("t1_k2", 32'(launched[2]), 32'h3);
        chk("t1_lat", 32'(lat_err), 0);
        // stray dec_done and start in a terminal state change nothing
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        go();
        step();
        chk("t1_stray_att", 32'(ksif.attempts), 3);
        chk("t1_stray_rd", 32'(n_rd), 3);
        chk("t1_stray_ds", 32'(n_ds), 3);
        chk("t1_stray_found", 32'(ksif.found), 1);

        // 2: source never drops available, slow core
        keys = '{4'h1, 4'h2, 4'h3};
        verd = '{1'b0, 1'b0, 1'b1};
        lat = 10; nogap = 1;
        do_reset();
        go();
        wait_term("t2_done", 300);
        chk("t2_nrd", 32'(n_rd), 3);
        chk("t2_nds", 32'(n_ds), 3);
        chk("t2_dup", 32'(dup), 0);
        chk("t2_fkey", 32'(ksif.found_key), 32'h3);
        chk("t2_att", 32'(ksif.attempts), 3);

        // 3: 15 invalid keys then finished
        keys.delete();
        for (int i = 1; i <= 15; i++) keys.push_back(KW'(i));
        verd.delete();
        lat = 1; nogap = 0; fin_en = 1;
        do_reset();
        go();
        wait_term("t3_done", 400);
        chk("t3_exh", 32'(ksif.exhausted), 1);
        chk("t3_found", 32'(ksif.found), 0);
        chk("t3_att", 32'(ksif.attempts), 15);
        chk("t3_nrd", 32'(n_rd), 15);
        chk("t3_badrd", 32'(bad_rd), 0);
        chk("t3_klast", 32'(launched[14]), 32'hF);
        chk("t3_busy", 32'(ksif.busy), 0);

        // 4: available and finished together
        keys = '{4'h5};
        fin_en = 0; fin_force = 1;
        do_reset();
        go();
        wait_term("t4_done", 20);
        chk("t4_exh", 32'(ksif.exhausted), 1);
        chk("t4_nrd", 32'(n_rd), 0);
        chk("t4_att", 32'(ksif.attempts), 0);

        // 5: reset while waiting on the third decrypt, then restart
        keys = '{4'h1, 4'h2, 4'h3, 4'h4};
        verd = '{1'b0, 1'b0, 1'b1};
        fin_force = 0; lat = 5;
        do_reset();
        go();
        begin
            int k = 0;
            while (n_ds < 3 && k < 200) begin step(); k++; end
            chk("t5_reach", 32'(k < 200), 1);
        end
        chk("t5_att_pre", 32'(ksif.attempts), 2);
        reset = 1'b1;
        step();
        chk("t5_att", 32'(ksif.attempts), 0);
        chk("t5_busy", 32'(ksif.busy), 0);
        chk("t5_dkey", 32'(ksif.dec_key), 0);
        chk("t5_ds", 32'(ksif.dec_start), 0);
        chk("t5_found", 32'(ksif.found), 0);
        reset = 1'b0;
        go();
        wait_term("t5_done", 200);
        chk("t5_fkey", 32'(ksif.found_key), 32'h3);
        chk("t5_att_post", 32'(ksif.attempts), 3);

        // 6: core never answers
        keys = '{4'h9};
        verd.delete();
        core_en = 0;
        do_reset();
        go();
        begin
            int k = 0;
            while (n_ds < 1 && k < 50) begin step(); k++; end
            chk("t6_launch", 32'(k < 50), 1);
        end
`ifdef KEY_SEARCH_TIMEOUT_EN
        begin
            int k = 0;
            while (!ksif.timeout && k < 50) begin step(); k++; end
            chk("t6_to_lat", 32'(k), 8);
        end
        chk("t6_to", 32'(ksif.timeout), 1);
        chk("t6_busy", 32'(ksif.busy), 0);
        chk("t6_att", 32'(ksif.attempts), 0);
        chk("t6_found", 32'(ksif.found), 0);
`else
        repeat (40) step();
        chk("t6_busy", 32'(ksif.busy), 1);
        chk("t6_to", 32'(ksif.timeout), 0);
        chk("t6_att", 32'(ksif.attempts), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
